// File: rtl/mr_execute_if.sv
// mr_pkg / mr_id_if / mr_ex_if
// Shared memory-op encodings plus the two handshake buses around the
// execute stage.
//   mr_id_if : decode -> execute. Carries the instruction (ALU op,
//              operands, immediate, memory op/size/sign, destination)
//              under id_valid_i / id_ready_o.
//              master = decode side, slave = execute side.
//   mr_ex_if : execute -> load/store. Carries the result (op, size,
//              sign, address/ALU result, store payload, destination)
//              under ex_valid_o / ex_ready_i.
//              master = execute side, slave = load/store side.

package mr_pkg;
    typedef enum logic [1:0] {
        MEMOP_NONE  = 2'd0,
        MEMOP_LOAD  = 2'd1,
        MEMOP_STORE = 2'd2
    } e_memops;

    typedef enum logic [1:0] {
        MEMSZ_1B = 2'd0,
        MEMSZ_2B = 2'd1,
        MEMSZ_4B = 2'd2
    } e_memsz;
endpackage

interface mr_id_if
    import mr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REGSEL_BITS = 5
);
    logic                   id_valid_i;
    logic                   id_ready_o;
    logic [3:0]             id_alu_op_i;
    logic [XLEN-1:0]        id_rs1_i;
    logic [XLEN-1:0]        id_rs2_i;
    logic [XLEN-1:0]        id_imm_i;
    logic                   id_use_imm_i;
    e_memops                id_mem_op_i;
    e_memsz                 id_mem_size_i;
    logic                   id_mem_signed_i;
    logic [REGSEL_BITS-1:0] id_dst_reg_i;

    modport master (
        output id_valid_i, id_alu_op_i, id_rs1_i, id_rs2_i, id_imm_i,
               id_use_imm_i, id_mem_op_i, id_mem_size_i, id_mem_signed_i,
               id_dst_reg_i,
        input  id_ready_o
    );

    modport slave (
        input  id_valid_i, id_alu_op_i, id_rs1_i, id_rs2_i, id_imm_i,
               id_use_imm_i, id_mem_op_i, id_mem_size_i, id_mem_signed_i,
               id_dst_reg_i,
        output id_ready_o
    );
endinterface

interface mr_ex_if
    import mr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REGSEL_BITS = 5
);
    e_memops                ex_op_o;
    e_memsz                 ex_size_o;
    logic                   ex_signed_o;
    logic [XLEN-1:0]        ex_addr_o;
    logic [XLEN-1:0]        ex_payload_o;
    logic [REGSEL_BITS-1:0] ex_dst_reg_o;
    logic                   ex_valid_o;
    logic                   ex_ready_i;

    modport master (
        output ex_op_o, ex_size_o, ex_signed_o, ex_addr_o, ex_payload_o,
               ex_dst_reg_o, ex_valid_o,
        input  ex_ready_i
    );

    modport slave (
        input  ex_op_o, ex_size_o, ex_signed_o, ex_addr_o, ex_payload_o,
               ex_dst_reg_o, ex_valid_o,
        output ex_ready_i
    );
endinterface

// File: rtl/mr_execute.sv
// mr_execute
// Execute stage: computes an ALU result or an effective memory address
// from the decoded instruction and hands it to load/store through a
// registered output stage with a one-entry skid buffer, so ex_ready_i
// never reaches id_ready_o combinationally.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   id   : decode bus (slave side)
//   ex   : load/store bus (master side)
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | M empty, S empty, ready for decode
// ST_FULL  | M holds the presented entry, S empty
// ST_SKID  | M and S both hold entries, decode stalled

module mr_execute
    import mr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REGSEL_BITS = 5
) (
    input logic     clk,
    input logic     rst,
    mr_id_if.slave  id,
    mr_ex_if.master ex
);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        e_memops                op;
        e_memsz                 size;
        logic                   sgn;
        logic [XLEN-1:0]        addr;
        logic [XLEN-1:0]        payload;
        logic [REGSEL_BITS-1:0] dst;
    } entry_t;

    localparam entry_t ENTRY_RST = '{
        op:      MEMOP_NONE,
        size:    MEMSZ_4B,
        sgn:     1'b0,
        addr:    '0,
        payload: '0,
        dst:     '0
    };

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } state_t;

    state_t          state;
    entry_t          m_q;
    entry_t          s_q;
    logic            valid_q;
    logic            ready_q;

    logic [XLEN-1:0] opb;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    entry_t          entry_d;
    logic            accept;
    logic            xfer;

    always_comb begin
        opb     = id.id_use_imm_i ? id.id_imm_i : id.id_rs2_i;
        shamt   = opb[4:0];
        alu_res = id.id_rs1_i + opb;
        case (id.id_alu_op_i)
            ALU_SUB:   alu_res = id.id_rs1_i - opb;
            ALU_SLL:   alu_res = id.id_rs1_i << shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(id.id_rs1_i) < $signed(opb)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, id.id_rs1_i < opb};
            ALU_XOR:   alu_res = id.id_rs1_i ^ opb;
            ALU_SRL:   alu_res = id.id_rs1_i >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(id.id_rs1_i) >>> shamt);
            ALU_OR:    alu_res = id.id_rs1_i | opb;
            ALU_AND:   alu_res = id.id_rs1_i & opb;
            ALU_PASSB: alu_res = opb;
            default:   alu_res = id.id_rs1_i + opb;
        endcase

        entry_d.op      = id.id_mem_op_i;
        entry_d.size    = id.id_mem_size_i;
        entry_d.sgn     = id.id_mem_signed_i;
        entry_d.dst     = id.id_dst_reg_i;
        entry_d.addr    = alu_res;
        entry_d.payload = '0;
        // Memory ops always form rs1 + imm, whatever the ALU fields say.
        if (id.id_mem_op_i != MEMOP_NONE) begin
            entry_d.addr = id.id_rs1_i + id.id_imm_i;
        end
        if (id.id_mem_op_i == MEMOP_STORE) begin
            entry_d.payload = id.id_rs2_i;
        end
    end

    // ready_q is low only in ST_SKID, so accept can never fire there.
    assign accept = id.id_valid_i & ready_q;
    assign xfer   = valid_q & ex.ex_ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_EMPTY;
            m_q     <= ENTRY_RST;
            s_q     <= ENTRY_RST;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_q     <= entry_d;
                        valid_q <= 1'b1;
                        state   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    case ({accept, xfer})
                        2'b10: begin
                            s_q     <= entry_d;
                            ready_q <= 1'b0;
                            state   <= ST_SKID;
                        end
                        2'b01: begin
                            valid_q <= 1'b0;
                            state   <= ST_EMPTY;
                        end
                        2'b11: begin
                            m_q <= entry_d;
                        end
                        default: ;
                    endcase
                end
                ST_SKID: begin
                    if (xfer) begin
                        m_q     <= s_q;
                        ready_q <= 1'b1;
                        state   <= ST_FULL;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign id.id_ready_o     = ready_q;
    assign ex.ex_valid_o     = valid_q;
    assign ex.ex_op_o        = m_q.op;
    assign ex.ex_size_o      = m_q.size;
    assign ex.ex_signed_o    = m_q.sgn;
    assign ex.ex_addr_o      = m_q.addr;
    assign ex.ex_payload_o   = m_q.payload;
    assign ex.ex_dst_reg_o   = m_q.dst;

endmodule

// File: tb/tb_mr_execute.sv
// tb_mr_execute
// Directed and randomized bench for mr_execute. A queue of expected
// results (computed from the instruction semantics) is pushed on every
// accept and popped on every transfer; occupancy of that queue also
// predicts ex_valid_o and id_ready_o each cycle.

module tb_mr_execute;
    import mr_pkg::*;

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        use_imm;
        e_memops     mem;
        e_memsz      size;
        logic        sgn;
        logic [4:0]  dst;
    } instr_t;

    typedef struct packed {
        e_memops     op;
        e_memsz      size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] payload;
        logic [4:0]  dst;
    } exp_t;

    logic clk;
    logic rst;

    mr_id_if id_bus ();
    mr_ex_if ex_bus ();

    mr_execute dut (
        .clk (clk),
        .rst (rst),
        .id  (id_bus),
        .ex  (ex_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    instr_t      cur;
    logic        cur_valid;
    logic        ex_rdy;
    logic        last_accept;
    logic        stall_prev;
    exp_t        held;
    exp_t        q[$];
    logic [31:0] xlog[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input instr_t i);
        exp_t        e;
        logic [31:0] b;
        int unsigned sh;
        e.op      = i.mem;
        e.size    = i.size;
        e.sgn     = i.sgn;
        e.dst     = i.dst;
        e.payload = 32'd0;
        if (i.mem != MEMOP_NONE) begin
            e.addr = i.rs1 + i.imm;
            if (i.mem == MEMOP_STORE) e.payload = i.rs2;
        end else begin
            b  = i.use_imm ? i.imm : i.rs2;
            sh = b % 32;
            case (i.alu)
                4'd1:    e.addr = i.rs1 - b;
                4'd2:    e.addr = i.rs1 << sh;
                4'd3:    e.addr = (int'(i.rs1) < int'(b)) ? 32'd1 : 32'd0;
                4'd4:    e.addr = (i.rs1 < b) ? 32'd1 : 32'd0;
                4'd5:    e.addr = i.rs1 ^ b;
                4'd6:    e.addr = i.rs1 >> sh;
                4'd7:    e.addr = i.rs1[31] ? ~((~i.rs1) >> sh) : (i.rs1 >> sh);
                4'd8:    e.addr = i.rs1 | b;
                4'd9:    e.addr = i.rs1 & b;
                4'd10:   e.addr = b;
                default: e.addr = i.rs1 + b;
            endcase
        end
        return e;
    endfunction

    function automatic instr_t rand_instr();
        instr_t      i;
        logic [1:0]  t;
        i.alu     = 4'($urandom_range(0, 15));
        i.rs1     = $urandom;
        i.rs2     = $urandom;
        i.imm     = $urandom;
        i.use_imm = 1'($urandom_range(0, 1));
        t         = 2'($urandom_range(0, 2));
        i.mem     = e_memops'(t);
        t         = 2'($urandom_range(0, 2));
        i.size    = e_memsz'(t);
        i.sgn     = 1'($urandom_range(0, 1));
        i.dst     = 5'($urandom);
        return i;
    endfunction

    function automatic instr_t mk(input logic [3:0] alu, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm,
                                  input logic use_imm, input e_memops mem,
                                  input logic [4:0] dst);
        instr_t i;
        i.alu = alu; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.use_imm = use_imm;
        i.mem = mem; i.size = MEMSZ_4B; i.sgn = 1'b0; i.dst = dst;
        return i;
    endfunction

    function automatic exp_t dut_out();
        exp_t o;
        o.op      = ex_bus.ex_op_o;
        o.size    = ex_bus.ex_size_o;
        o.sgn     = ex_bus.ex_signed_o;
        o.addr    = ex_bus.ex_addr_o;
        o.payload = ex_bus.ex_payload_o;
        o.dst     = ex_bus.ex_dst_reg_o;
        return o;
    endfunction

    // One clock cycle: drive inputs, check against the model, step past
    // the rising edge and return at the following falling edge.
    task automatic tick();
        exp_t o;
        logic acc;
        logic xf;
        id_bus.id_valid_i      = cur_valid;
        id_bus.id_alu_op_i     = cur.alu;
        id_bus.id_rs1_i        = cur.rs1;
        id_bus.id_rs2_i        = cur.rs2;
        id_bus.id_imm_i        = cur.imm;
        id_bus.id_use_imm_i    = cur.use_imm;
        id_bus.id_mem_op_i     = cur.mem;
        id_bus.id_mem_size_i   = cur.size;
        id_bus.id_mem_signed_i = cur.sgn;
        id_bus.id_dst_reg_i    = cur.dst;
        ex_bus.ex_ready_i      = ex_rdy;
        if (rst) begin
            o = dut_out();
            chk("ex_valid", 128'(ex_bus.ex_valid_o), 128'(q.size() > 0));
            chk("id_ready", 128'(id_bus.id_ready_o), 128'(q.size() < 2));
            if (stall_prev && ex_bus.ex_valid_o) chk("hold", o, held);
            xf  = ex_bus.ex_valid_o & ex_rdy;
            acc = cur_valid & id_bus.id_ready_o;
            if (xf && q.size() > 0) begin
                chk("order", o, q.pop_front());
                xlog.push_back(o.addr);
            end
            if (acc) begin
                q.push_back(model(cur));
                n_acc++;
            end
            stall_prev  = ex_bus.ex_valid_o & ~ex_rdy;
            held        = o;
            last_accept = acc;
        end else begin
            q.delete();
            stall_prev  = 1'b0;
            last_accept = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input instr_t i);
        cur       = i;
        cur_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_accept) break;
        end
        cur_valid = 1'b0;
        chk("send_accept", 128'(last_accept), 128'(1'b1));
    endtask

    logic [3:0]  sw_op  [8] = '{4'd7, 4'd6, 4'd3, 4'd4, 4'd1, 4'd2, 4'd10, 4'd13};
    logic [31:0] sw_b   [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd33, 32'h1234, 32'd1};
    logic        sw_imm [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] sw_exp [8] = '{32'hC000_0000, 32'h4000_0000, 32'd1, 32'd0,
                                32'h7FFF_FFFF, 32'h0000_0000, 32'h1234, 32'h8000_0001};

    initial begin
        exp_t   rst_exp;
        instr_t i;
        logic [31:0] bp_addr [4];
        int cycles;

        cur         = '0;
        cur.size    = MEMSZ_4B;
        cur_valid   = 1'b0;
        ex_rdy      = 1'b0;
        last_accept = 1'b0;
        stall_prev  = 1'b0;
        held        = '0;
        rst         = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        rst_exp = '{op: MEMOP_NONE, size: MEMSZ_4B, sgn: 1'b0, addr: 32'd0,
                    payload: 32'd0, dst: 5'd0};
        chk("rst_valid", 128'(ex_bus.ex_valid_o), 128'(1'b0));
        chk("rst_ready", 128'(id_bus.id_ready_o), 128'(1'b1));
        chk("rst_outputs", dut_out(), rst_exp);

        // Basic ADD, visible right after the accepting edge.
        ex_rdy = 1'b1;
        send(mk(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, MEMOP_NONE, 5'd3));
        chk("add_valid", 128'(ex_bus.ex_valid_o), 128'(1'b1));
        chk("add_op", 128'(ex_bus.ex_op_o), 128'(MEMOP_NONE));
        chk("add_addr", 128'(ex_bus.ex_addr_o), 128'(32'd12));
        chk("add_dst", 128'(ex_bus.ex_dst_reg_o), 128'(5'd3));

        // ALU sweep on rs1 = 0x8000_0000, back to back.
        for (int k = 0; k < 8; k++) begin
            if (sw_imm[k]) i = mk(sw_op[k], 32'h8000_0000, 32'hFFFF_FFFF, sw_b[k], 1'b1, MEMOP_NONE, 5'd1);
            else           i = mk(sw_op[k], 32'h8000_0000, sw_b[k], 32'h55, 1'b0, MEMOP_NONE, 5'd1);
            send(i);
            chk($sformatf("alu_sweep_%0d", k), 128'(ex_bus.ex_addr_o), 128'(sw_exp[k]));
        end

        // STORE address wraps; ALU fields must not matter.
        send(mk(4'd1, 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b0, MEMOP_STORE, 5'd0));
        chk("st_addr", 128'(ex_bus.ex_addr_o), 128'(32'h0FFC));
        chk("st_payload", 128'(ex_bus.ex_payload_o), 128'(32'hDEAD_BEEF));
        chk("st_op", 128'(ex_bus.ex_op_o), 128'(MEMOP_STORE));
        send(mk(4'd5, 32'h2000, 32'h1111_1111, 32'd8, 1'b1, MEMOP_LOAD, 5'd9));
        chk("ld_addr", 128'(ex_bus.ex_addr_o), 128'(32'h2008));
        chk("ld_payload", 128'(ex_bus.ex_payload_o), 128'(32'd0));
        for (int k = 0; k < 3; k++) tick();

        // Back-pressure: A, B, C, D with load/store stalled.
        bp_addr = '{32'hA, 32'hB, 32'hC, 32'hD};
        xlog.delete();
        ex_rdy = 1'b0;
        send(mk(4'd10, 32'd0, bp_addr[0], 32'd0, 1'b0, MEMOP_NONE, 5'd10));
        chk("bp_a_ready", 128'(id_bus.id_ready_o), 128'(1'b1));
        send(mk(4'd10, 32'd0, bp_addr[1], 32'd0, 1'b0, MEMOP_NONE, 5'd11));
        chk("bp_b_ready", 128'(id_bus.id_ready_o), 128'(1'b0));
        chk("bp_a_held", 128'(ex_bus.ex_addr_o), 128'(bp_addr[0]));
        cur       = mk(4'd10, 32'd0, bp_addr[2], 32'd0, 1'b0, MEMOP_NONE, 5'd12);
        cur_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_c_stalled", 128'(last_accept), 128'(1'b0));
            chk("bp_a_stable", 128'(ex_bus.ex_addr_o), 128'(bp_addr[0]));
        end
        ex_rdy = 1'b1;
        send(mk(4'd10, 32'd0, bp_addr[2], 32'd0, 1'b0, MEMOP_NONE, 5'd12));
        send(mk(4'd10, 32'd0, bp_addr[3], 32'd0, 1'b0, MEMOP_NONE, 5'd13));
        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        chk("bp_count", 128'(xlog.size()), 128'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < xlog.size()) chk($sformatf("bp_order_%0d", k), 128'(xlog[k]), 128'(bp_addr[k]));
        end

        // Reset while in SKID flushes both entries.
        ex_rdy = 1'b0;
        send(mk(4'd0, 32'h100, 32'd1, 32'd0, 1'b0, MEMOP_NONE, 5'd4));
        send(mk(4'd0, 32'h200, 32'd1, 32'd0, 1'b0, MEMOP_NONE, 5'd5));
        chk("skid_ready", 128'(id_bus.id_ready_o), 128'(1'b0));
        rst       = 1'b0;
        cur       = mk(4'd0, 32'h300, 32'd1, 32'd0, 1'b0, MEMOP_NONE, 5'd6);
        cur_valid = 1'b1;
        ex_rdy    = 1'b1;
        tick();
        rst       = 1'b1;
        cur_valid = 1'b0;
        chk("flush_valid", 128'(ex_bus.ex_valid_o), 128'(1'b0));
        chk("flush_ready", 128'(id_bus.id_ready_o), 128'(1'b1));
        xlog.delete();
        for (int k = 0; k < 5; k++) tick();
        chk("flush_no_stale", 128'(xlog.size()), 128'(0));

        // Random traffic, 50% valid and 50% ready.
        n_acc     = 0;
        cur_valid = 1'b0;
        cycles    = 0;
        while (n_acc < 10000 && cycles < 60000) begin
            if (!(cur_valid && !last_accept)) begin
                cur_valid = 1'($urandom_range(0, 1));
                if (cur_valid) cur = rand_instr();
            end
            ex_rdy = 1'($urandom_range(0, 1));
            tick();
            cycles++;
        end
        chk("rand_count", 128'(n_acc >= 10000), 128'(1'b1));
        cur_valid = 1'b0;
        ex_rdy    = 1'b1;
        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        chk("rand_drain", 128'(q.size()), 128'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
